// File: rtl/weight_pkg.sv
// Shared defaults and FSM encoding for the weight streaming controller.
package weight_pkg;

    localparam int WS_DW    = 16;
    localparam int WS_AW    = 5;
    localparam int WS_DEPTH = 28;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READ,
        ST_DRAIN
    } ws_state_e;

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry FIFO holding BRAM read words with a last-word tag.
module weight_skid_fifo #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          push_last,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          head_last,
    output logic          head_valid,
    output logic [1:0]    count
);

    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          l0;
    logic          l1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0    <= '0;
            d1    <= '0;
            l0    <= 1'b0;
            l1    <= 1'b0;
            count <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        d0 <= push_data;
                        l0 <= push_last;
                    end else begin
                        d1 <= push_data;
                        l1 <= push_last;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    d0    <= d1;
                    l0    <= l1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Head leaves while a new word arrives; occupancy unchanged.
                    if (count == 2'd1) begin
                        d0 <= push_data;
                        l0 <= push_last;
                    end else begin
                        d0 <= d1;
                        l0 <= l1;
                        d1 <= push_data;
                        l1 <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_valid = (count != 2'd0);
    assign head_data  = d0;
    assign head_last  = l0 & head_valid;

endmodule

// File: rtl/weight_stream_ctrl.sv
// Loads a weight BRAM from a stream and replays it as a gap-free stream.
module weight_stream_ctrl
    import weight_pkg::*;
#(
    parameter int DW    = WS_DW,
    parameter int AW    = WS_AW,
    parameter int DEPTH = WS_DEPTH
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START_LOAD,
    input  logic          START_READ,
    output logic          BUSY,
    output logic          DONE,
    input  logic [DW-1:0] S_DATA,
    input  logic          S_VALID,
    output logic          S_READY,
    output logic [DW-1:0] M_DATA,
    output logic          M_VALID,
    input  logic          M_READY,
    output logic          M_LAST,
    output logic [AW-1:0] BRAM_ADDR,
    output logic [DW-1:0] BRAM_DI,
    output logic          BRAM_EN,
    output logic          BRAM_WE,
    input  logic [DW-1:0] BRAM_DO
);

    ws_state_e     state;
    logic [AW-1:0] cnt;
    logic [1:0]    fifo_cnt;
    logic          at_end;
    logic          pop;
    logic          wr;
    logic          rd;

    assign at_end = (cnt == AW'(DEPTH - 1));
    assign pop    = M_VALID & M_READY;
    assign wr     = (state == ST_LOAD) & S_VALID;
    // Read data lands in the FIFO at the next edge, so only room matters.
    assign rd     = (state == ST_READ) & ((fifo_cnt < 2'd2) | pop);

    assign BUSY    = (state != ST_IDLE);
    assign S_READY = (state == ST_LOAD);

    always_comb begin
        BRAM_ADDR = cnt;
        BRAM_DI   = S_DATA;
        BRAM_EN   = wr | rd;
        BRAM_WE   = wr;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            cnt   <= '0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (START_LOAD) begin
                        state <= ST_LOAD;
                        cnt   <= '0;
                    end else if (START_READ) begin
                        state <= ST_READ;
                        cnt   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (wr) begin
                        if (at_end) begin
                            state <= ST_IDLE;
                            DONE  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (rd) begin
                        if (at_end) state <= ST_DRAIN;
                        else        cnt   <= cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (pop & M_LAST) begin
                        state <= ST_IDLE;
                        DONE  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    weight_skid_fifo #(
        .DW(DW)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (rd),
        .push_data (BRAM_DO),
        .push_last (at_end),
        .pop       (pop),
        .head_data (M_DATA),
        .head_last (M_LAST),
        .head_valid(M_VALID),
        .count     (fifo_cnt)
    );

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Randomized bench for weight_stream_ctrl against a BRAM model and word-order reference.
module tb_weight_stream_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 28;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          START_LOAD;
    logic          START_READ;
    logic          BUSY;
    logic          DONE;
    logic [DW-1:0] S_DATA;
    logic          S_VALID;
    logic          S_READY;
    logic [DW-1:0] M_DATA;
    logic          M_VALID;
    logic          M_READY;
    logic          M_LAST;
    logic [AW-1:0] BRAM_ADDR;
    logic [DW-1:0] BRAM_DI;
    logic          BRAM_EN;
    logic          BRAM_WE;
    logic [DW-1:0] BRAM_DO;

    logic [DW-1:0] bram    [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    weight_stream_ctrl #(
        .DW(DW),
        .AW(AW),
        .DEPTH(DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START_LOAD(START_LOAD),
        .START_READ(START_READ),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .S_DATA    (S_DATA),
        .S_VALID   (S_VALID),
        .S_READY   (S_READY),
        .M_DATA    (M_DATA),
        .M_VALID   (M_VALID),
        .M_READY   (M_READY),
        .M_LAST    (M_LAST),
        .BRAM_ADDR (BRAM_ADDR),
        .BRAM_DI   (BRAM_DI),
        .BRAM_EN   (BRAM_EN),
        .BRAM_WE   (BRAM_WE),
        .BRAM_DO   (BRAM_DO)
    );

    // BRAM samples its controls on the falling edge.
    always @(negedge CLK) begin
        if (BRAM_EN && 32'(BRAM_ADDR) < DEPTH) begin
            if (BRAM_WE) bram[BRAM_ADDR] <= BRAM_DI;
            else         BRAM_DO <= bram[BRAM_ADDR];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},   32'(BUSY),    0);
        chk({tag, "_done"},   32'(DONE),    0);
        chk({tag, "_sready"}, 32'(S_READY), 0);
        chk({tag, "_mvalid"}, 32'(M_VALID), 0);
        chk({tag, "_mlast"},  32'(M_LAST),  0);
        chk({tag, "_mdata"},  32'(M_DATA),  0);
        chk({tag, "_en"},     32'(BRAM_EN), 0);
        chk({tag, "_we"},     32'(BRAM_WE), 0);
    endtask

    // mode 0: S_VALID steady, 1: toggling, 2: random
    task automatic do_load(input int mode, input bit both);
        logic [DW-1:0] wd [DEPTH];
        int  idx = 0;
        bit  fin = 0;
        for (int i = 0; i < DEPTH; i++)
            wd[i] = (mode == 0) ? DW'(i) : DW'($urandom);
        @(posedge CLK); #1;
        START_LOAD = 1'b1;
        START_READ = both;
        S_VALID    = 1'b0;
        @(posedge CLK); #1;
        START_LOAD = 1'b0;
        START_READ = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            if (mode == 0)      S_VALID = 1'b1;
            else if (mode == 1) S_VALID = (c % 2 == 0);
            else                S_VALID = 1'($urandom_range(1));
            S_DATA     = (idx < DEPTH) ? wd[idx] : '0;
            START_READ = (idx < DEPTH) ? 1'($urandom_range(1)) : 1'b0;
            @(negedge CLK);
            if (idx == DEPTH) begin
                chk("load_done", 32'(DONE), 1);
                chk("load_busy", 32'(BUSY), 0);
                fin = 1;
            end else begin
                chk("load_done_early", 32'(DONE), 0);
                chk("load_sready", 32'(S_READY), 1);
                if (S_VALID) begin
                    chk("load_en_we", 32'({BRAM_EN, BRAM_WE}), 3);
                    chk("load_addr", 32'(BRAM_ADDR), 32'(idx));
                    chk("load_di", 32'(BRAM_DI), 32'(wd[idx]));
                    ref_mem[idx] = wd[idx];
                    idx++;
                end else begin
                    chk("load_en_idle", 32'(BRAM_EN), 0);
                end
            end
            @(posedge CLK); #1;
        end
        S_VALID    = 1'b0;
        START_READ = 1'b0;
        if (!fin) chk("load_timeout", 0, 1);
    endtask

    // mode 0: M_READY high, 1: stall 5 cycles at word 3, 2: random
    task automatic do_read(input int mode, input int abort_at);
        int exp_w  = 0;
        int issued = 0;
        int stall  = 0;
        bit pend   = 0;
        bit fin    = 0;
        @(posedge CLK); #1;
        START_READ = 1'b1;
        @(posedge CLK); #1;
        START_READ = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            if (abort_at >= 0 && exp_w == abort_at) begin
                RST_N = 1'b0;
                #1;
                chk_reset_outputs("abort");
                @(negedge CLK);
                RST_N   = 1'b1;
                M_READY = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge CLK);
                    chk("abort_no_done", 32'(DONE), 0);
                end
                return;
            end
            if (mode == 0)      M_READY = 1'b1;
            else if (mode == 1) M_READY = !(exp_w == 3 && stall < 5);
            else                M_READY = 1'($urandom_range(1));
            @(negedge CLK);
            if (pend) begin
                chk("read_done", 32'(DONE), 1);
                chk("read_busy", 32'(BUSY), 0);
                fin = 1;
            end else begin
                chk("read_done_early", 32'(DONE), 0);
                chk("read_we", 32'(BRAM_WE), 0);
                chk("read_buffered", 32'(issued - exp_w <= 2), 1);
                if (c == 0) chk("read_first_gap", 32'(M_VALID), 0);
                if (mode == 0 && c >= 1) chk("read_cont", 32'(M_VALID), 1);
                if (BRAM_EN) begin
                    chk("read_addr", 32'(BRAM_ADDR), 32'(issued));
                    issued++;
                end
                if (M_VALID) begin
                    chk("read_data", 32'(M_DATA), 32'(ref_mem[exp_w]));
                    chk("read_last", 32'(M_LAST), 32'(exp_w == DEPTH - 1));
                    if (M_READY) begin
                        if (exp_w == DEPTH - 1) pend = 1;
                        exp_w++;
                    end else begin
                        stall++;
                    end
                end
            end
            @(posedge CLK); #1;
        end
        M_READY = 1'b0;
        if (!fin) chk("read_timeout", 0, 1);
        chk("read_issued", 32'(issued), DEPTH);
    endtask

    initial begin
        RST_N      = 1'b0;
        START_LOAD = 1'b0;
        START_READ = 1'b0;
        S_DATA     = '0;
        S_VALID    = 1'b0;
        M_READY    = 1'b0;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("idle_busy", 32'(BUSY), 0);

        do_load(0, 1'b0);
        do_read(0, -1);
        do_load(1, 1'b1);
        do_read(1, -1);
        do_read(0, 10);
        do_read(0, -1);
        do_load(2, 1'b1);
        do_read(2, -1);
        do_read(2, -1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/weight_stream_ctrl.md
WEIGHT_STREAM_CTRL -- requirements
Module: weight_stream_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning weight word width.
REQ-002 The block SHALL have parameter AW, default 5, meaning weight BRAM address width.
REQ-003 The block SHALL have parameter DEPTH, default 28, meaning words per weight BRAM (addresses 0..DEPTH-1).
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: CLK  in  1  sole clock, rising edge; RST_N  in  1  asynchronous reset, active low.
REQ-005 The block SHALL have ports: START_LOAD in 1 load-command pulse; START_READ in 1 read-command pulse; BUSY out 1 operation in progress; DONE out 1 one-cycle completion pulse.
REQ-006 The block SHALL have load-stream ports: S_DATA in DW word to write; S_VALID in 1 word offered; S_READY out 1 word accepted.
REQ-007 The block SHALL have read-stream ports: M_DATA out DW weight word; M_VALID out 1 word valid; M_READY in 1 consumer accepts; M_LAST out 1 word is address DEPTH-1.
REQ-008 The block SHALL have BRAM-side ports: BRAM_ADDR out AW; BRAM_DI out DW; BRAM_EN out 1; BRAM_WE out 1; BRAM_DO in DW.

Function
REQ-009 The attached BRAM SHALL be treated as sampling ADDR/EN/WE/DI on falling CLK, so a read issued in cycle n yields BRAM_DO valid at rising edge n+1.
REQ-010 FSM states SHALL be IDLE, LOAD, READ, DRAIN; BUSY=1 in every state except IDLE.
REQ-011 In IDLE, START_LOAD SHALL enter LOAD and START_READ SHALL enter READ, both with address counter cleared to 0; if both are high, LOAD wins.
REQ-012 START_LOAD and START_READ SHALL be ignored outside IDLE.
REQ-013 In LOAD, S_READY SHALL be 1; each S_VALID&S_READY cycle SHALL drive BRAM_EN=1, BRAM_WE=1, BRAM_ADDR=counter, BRAM_DI=S_DATA combinationally and increment the counter.
REQ-014 The write at address DEPTH-1 SHALL return to IDLE with DONE=1 the following cycle; counter SHALL NOT wrap.
REQ-015 In READ, a read issue (BRAM_EN=1, BRAM_WE=0, BRAM_ADDR=counter) SHALL occur only when FIFO occupancy plus in-flight reads minus this cycle's pop is below 2.
REQ-016 Each returning BRAM_DO word SHALL be pushed into a 2-entry FIFO at the rising edge after issue, tagged last if its address was DEPTH-1.
REQ-017 M_DATA/M_VALID/M_LAST SHALL present the FIFO head; pop occurs on M_VALID&M_READY.
REQ-018 With M_READY held high, M_VALID SHALL be continuous: first word one cycle after READ entry, DEPTH words in DEPTH consecutive cycles.
REQ-019 M_DATA SHALL remain stable while M_VALID=1 and M_READY=0.
REQ-020 After issuing address DEPTH-1, the FSM SHALL enter DRAIN with no further BRAM_EN.
REQ-021 In DRAIN, the handshake of the M_LAST word SHALL return to IDLE and pulse DONE=1 the following cycle.
REQ-022 BRAM_EN SHALL be 0 in IDLE and DRAIN; BRAM_WE SHALL be 1 only in LOAD writes.

Reset
REQ-023 RST_N low SHALL force asynchronously: state IDLE, counter 0, FIFO empty, in-flight 0, BUSY=0, DONE=0, S_READY=0, M_VALID=0, M_LAST=0, M_DATA=0, BRAM_EN=0, BRAM_WE=0.
REQ-024 Reset mid-LOAD or mid-READ SHALL abort with no DONE; BRAM contents already written are not restored.

Structure
REQ-025 DW, AW, DEPTH defaults and the FSM state enumeration SHALL live in shared package weight_pkg.
REQ-026 The 2-entry FIFO with last tag SHALL be sub-module weight_skid_fifo; the FSM, counter and issue logic stay in weight_stream_ctrl.

Verification
REQ-027 Load 0x0000..0x001B with S_VALID held high -> 28 writes on consecutive cycles, BRAM_ADDR 0..27, DONE one cycle after addr 27.
REQ-028 Read after that load with M_READY=1 -> M_DATA 0x0000..0x001B on 28 consecutive cycles, M_LAST only on 0x001B, DONE next cycle.
REQ-029 Read with M_READY low 5 cycles at word 3 -> M_DATA holds 0x0003, at most 2 words buffered, no word lost or duplicated.
REQ-030 START_LOAD and START_READ same cycle in IDLE -> LOAD entered; START_READ during LOAD ignored.
REQ-031 RST_N low at read word 10 -> all outputs per REQ-023 immediately, no DONE; new START_READ restarts at address 0.
REQ-032 Load with S_VALID toggling every other cycle -> writes only on handshake cycles, addresses contiguous 0..27.
